// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - host pixel-write handshake between drawing logic and vram_arbiter
interface vram_arbiter_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_x;
    logic [7:0] wr_y;
    logic [7:0] wr_color;

    modport master (output wr_valid, wr_x, wr_y, wr_color, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_color, output wr_ready);
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares a single-port framebuffer RAM between VGA scan-out, host writes and a clear engine
module vram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_W       = 320,
    parameter int FB_H       = 240
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [9:0]    next_x,
    input  logic [9:0]    next_y,
    output logic [7:0]    color_out,
    output logic [16:0]   ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    vram_arbiter_if.slave wr,
    input  logic          clear_start,
    input  logic [7:0]    clear_color,
    output logic          busy
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(FIFO_DEPTH);
    localparam logic [16:0] LAST_ADDR = 17'(FB_W * FB_H - 1);
    localparam logic [8:0]  FB_W9     = 9'(FB_W);
    localparam logic [8:0]  FB_H9     = 9'(FB_H);

    typedef enum logic {IDLE, CLEAR} state_t;
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] color;
    } entry_t;

    entry_t        fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;
    state_t        state_q;
    logic          pend_q, busy_q, disp_rd_q;
    logic [7:0]    latch_q, clr_color_q;
    logic [16:0]   clr_addr_q;

    logic       disp_slot, host_slot, empty, full, push, pop, head_in_range;
    logic [8:0] disp_col, disp_row;
    entry_t     head;
    logic       unused_bits;

    function automatic logic [16:0] fb_addr(input logic [8:0] row, input logic [8:0] col);
        return ({8'd0, row} << 8) + ({8'd0, row} << 6) + {8'd0, col};
    endfunction

    // Odd x (and x==0) fetch the pixel for the next screen pair; even x are free for writes.
    assign disp_slot = (next_x == 10'd0) || (next_x[0] && next_x <= 10'd637);
    assign host_slot = !disp_slot;
    assign disp_col  = next_x[9:1] + {8'd0, next_x[0]};
    assign disp_row  = next_y[9:1];
    assign unused_bits = next_y[0];

    assign empty         = (count_q == '0);
    assign full          = (count_q == FULL_CNT);
    assign head          = fifo_q[rd_ptr_q];
    assign head_in_range = (head.x < FB_W9) && ({1'b0, head.y} < FB_H9);

    assign wr.wr_ready = !full && (state_q == IDLE) && !pend_q;
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = host_slot && (state_q == IDLE) && !empty;
    assign busy        = busy_q;
    assign color_out   = disp_rd_q ? ram_rdata : latch_q;

    always_comb begin
        ram_addr  = fb_addr(disp_row, disp_col);
        ram_we    = 1'b0;
        ram_wdata = clr_color_q;
        if (host_slot) begin
            if (state_q == CLEAR) begin
                ram_addr = clr_addr_q;
                ram_we   = 1'b1;
            end else if (!empty) begin
                // Out-of-range entries still consume the slot so the FIFO keeps draining.
                ram_addr  = fb_addr({1'b0, head.y}, head.x);
                ram_we    = head_in_range;
                ram_wdata = head.color;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= {wr.wr_x, wr.wr_y, wr.wr_color};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            disp_rd_q   <= 1'b0;
            latch_q     <= 8'd0;
            clr_color_q <= 8'd0;
            clr_addr_q  <= 17'd0;
        end else begin
            disp_rd_q <= disp_slot;
            if (disp_rd_q) latch_q <= ram_rdata;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;

            case (state_q)
                IDLE: begin
                    if (clear_start) clr_color_q <= clear_color;
                    // A same-cycle push would otherwise be stranded behind the clear.
                    if ((clear_start || pend_q) && empty && !push) begin
                        state_q    <= CLEAR;
                        busy_q     <= 1'b1;
                        pend_q     <= 1'b0;
                        clr_addr_q <= 17'd0;
                    end else if (clear_start) begin
                        pend_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (host_slot) begin
                        clr_addr_q <= clr_addr_q + 17'd1;
                        if (clr_addr_q == LAST_ADDR) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed bench for vram_arbiter with a behavioural single-port RAM
module tb_vram_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  next_x, next_y;
    logic [7:0]  color_out, ram_wdata, ram_rdata, clear_color;
    logic [16:0] ram_addr;
    logic        ram_we, clear_start, busy;

    logic [7:0]  mem [76800];
    bit          wrt [76800];
    int          vectors = 0, miscompares = 0, we_disp = 0;

    vram_arbiter_if wr ();

    vram_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .next_x     (next_x),
        .next_y     (next_y),
        .color_out  (color_out),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .wr         (wr),
        .clear_start(clear_start),
        .clear_color(clear_color),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Unwritten locations read back as pix(c,r) = c[7:0].
    always @(posedge clock) begin
        if (ram_we && ram_addr < 17'd76800) begin
            mem[ram_addr] <= ram_wdata;
            wrt[ram_addr] <= 1'b1;
        end
        if (ram_addr < 17'd76800)
            ram_rdata <= wrt[ram_addr] ? mem[ram_addr] : 8'(ram_addr % 17'd320);
        else
            ram_rdata <= 8'h00;
        if (ram_we && (next_x == 10'd0 || (next_x[0] && next_x <= 10'd637)))
            we_disp++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [8:0] x, input logic [7:0] y, input logic [7:0] c);
        wr.wr_x = x; wr.wr_y = y; wr.wr_color = c; wr.wr_valid = 1'b1;
        #1;
        chk("push_ready", wr.wr_ready, 1);
        tick();
        wr.wr_valid = 1'b0;
    endtask

    int widx, bad, found, cnt;
    logic [16:0] exp_a;
    logic [7:0]  exp_d;
    logic        exp_b;

    initial begin
        reset = 1'b0; next_x = 0; next_y = 0; clear_start = 0; clear_color = 0;
        wr.wr_valid = 0; wr.wr_x = 0; wr.wr_y = 0; wr.wr_color = 0;
        #1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", wr.wr_ready, 1);
        chk("rst_we", ram_we, 0);
        chk("rst_color", color_out, 0);
        reset = 1'b1;

        // Line sweep on row 2
        next_y = 10'd4;
        tick(); tick();
        for (int x = 0; x < 640; x++) begin
            next_x = 10'(x);
            #1;
            chk("sweep_color", color_out, 32'((x >> 1) & 8'hFF));
            tick();
        end
        next_x = 0; next_y = 0;
        tick();

        // Single write held off during blanking
        push(9'd5, 8'd3, 8'hE3);
        for (int i = 0; i < 3; i++) begin
            #1; chk("hold_we", ram_we, 0); tick();
        end
        next_x = 10'd2;
        #1;
        chk("hw_we", ram_we, 1);
        chk("hw_addr", ram_addr, 965);
        chk("hw_data", ram_wdata, 8'hE3);
        tick();
        next_x = 10'd4;
        #1; chk("hw_popped", ram_we, 0); tick();
        next_x = 0;

        // Burst of six: four accepted, drained in order on even x
        for (int i = 0; i < 6; i++) begin
            wr.wr_x = 9'(i * 10); wr.wr_y = 8'd7; wr.wr_color = 8'(8'h40 + i); wr.wr_valid = 1'b1;
            #1;
            chk("burst_ready", wr.wr_ready, 32'(i < 4));
            tick();
        end
        wr.wr_valid = 1'b0;
        for (int x = 1; x <= 10; x++) begin
            next_x = 10'(x);
            #1;
            if (x % 2 == 0 && x <= 8) begin
                chk("burst_we", ram_we, 1);
                chk("burst_addr", ram_addr, 32'(7 * 320 + (x / 2 - 1) * 10));
                chk("burst_data", ram_wdata, 32'(8'h40 + x / 2 - 1));
            end else begin
                chk("burst_idle_we", ram_we, 0);
            end
            tick();
        end
        next_x = 0;

        // Out-of-range entries are dropped but still dequeued
        push(9'd320, 8'd0, 8'hFF);
        push(9'd0, 8'd240, 8'hFF);
        push(9'd1, 8'd1, 8'h11);
        push(9'd2, 8'd1, 8'h22);
        #1; chk("oor_full", wr.wr_ready, 0);
        next_x = 10'd2;
        #1; chk("oor_drop_x", ram_we, 0); tick();
        #1; chk("oor_count_dec", wr.wr_ready, 1); chk("oor_drop_y", ram_we, 0); tick();
        next_x = 10'd3;
        #1; chk("oor_disp_we", ram_we, 0); tick();
        next_x = 10'd4;
        #1; chk("oor_w1_we", ram_we, 1); chk("oor_w1_addr", ram_addr, 321); chk("oor_w1_data", ram_wdata, 8'h11); tick();
        next_x = 10'd6;
        #1; chk("oor_w2_we", ram_we, 1); chk("oor_w2_addr", ram_addr, 322); chk("oor_w2_data", ram_wdata, 8'h22); tick();
        next_x = 0;

        // Clear with two queued writes: FIFO drains first, then 76800 fills
        push(9'd10, 8'd10, 8'hAA);
        push(9'd11, 8'd10, 8'hBB);
        clear_color = 8'h1C; clear_start = 1'b1;
        tick();
        clear_start = 1'b0; clear_color = 8'h00;
        #1;
        chk("clr_pend_busy", busy, 0);
        chk("clr_pend_ready", wr.wr_ready, 0);
        next_x = 10'd2;
        widx = 0; bad = 0; cnt = 0;
        while (widx < 76802 && cnt < 80000) begin
            #1;
            if (ram_we) begin
                if (widx < 2) begin
                    exp_a = 17'(3210 + widx); exp_d = (widx == 0) ? 8'hAA : 8'hBB; exp_b = 1'b0;
                end else begin
                    exp_a = 17'(widx - 2); exp_d = 8'h1C; exp_b = 1'b1;
                end
                if (ram_addr !== exp_a || ram_wdata !== exp_d || busy !== exp_b) bad++;
                widx++;
            end
            tick();
            cnt++;
        end
        chk("clr_write_count", widx, 76802);
        chk("clr_bad_writes", bad, 0);
        #1;
        chk("clr_done_busy", busy, 0);
        chk("clr_done_we", ram_we, 0);
        chk("clr_done_ready", wr.wr_ready, 1);
        tick();

        // Reset asserted mid-clear at address 1000
        next_x = 0;
        clear_color = 8'h55; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        next_x = 10'd2;
        found = 0; cnt = 0;
        while (!found && cnt < 2000) begin
            #1;
            if (ram_we && ram_addr == 17'd1000) found = 1;
            else begin tick(); cnt++; end
        end
        chk("mid_reached_1000", found, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_ready", wr.wr_ready, 1);
        tick(); tick();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ram_we) cnt++;
            tick();
        end
        chk("mid_no_writes", cnt, 0);
        chk("mid_idle_busy", busy, 0);
        chk("no_we_in_disp_slot", we_disp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
